// File: rtl/wb_pkg.sv
// Shared widths and queue entry type for the register-file writeback path.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending writebacks: up to two pushes and one pop per cycle,
// with the contents presented oldest-first for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push0,
  input  wb_entry_t             i_entry0,
  input  logic                  i_push1,
  input  wb_entry_t             i_entry1,
  input  logic                  i_pop,
  output logic [CNT_W-1:0]      o_count,
  output wb_entry_t [DEPTH-1:0] o_age_entry,
  output logic [DEPTH-1:0]      o_age_valid
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_tail1;
  logic                  w_pop;

  // When push0 is absent the second entry takes the tail slot itself.
  assign w_tail1 = r_tail + PTR_W'(i_push0);
  assign w_pop   = i_pop & (r_count != {CNT_W{1'b0}});
  assign o_count = r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= {DEPTH{{ADDR_W{1'b0}}, {DATA_W{1'b0}}}};
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (i_push0) begin
        r_mem[r_tail] <= i_entry0;
      end
      if (i_push1) begin
        r_mem[w_tail1] <= i_entry1;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_tail  <= r_tail + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(w_pop);
    end
  end

  // Index 0 is the head (oldest); higher indices are progressively younger.
  always_comb begin
    o_age_entry = {DEPTH{{ADDR_W{1'b0}}, {DATA_W{1'b0}}}};
    o_age_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      o_age_entry[i] = r_mem[r_head + PTR_W'(i)];
      o_age_valid[i] = (CNT_W'(i) < r_count);
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and load results into the single register-file write port and
// forwards values that are queued or on the port but not yet committed.
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              enableWrite,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  input  logic [ADDR_W-1:0] fwd_ra,
  input  logic [ADDR_W-1:0] fwd_rb,
  output logic              fwd_a_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic              empty
);

  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_free;
  logic                  w_alu_push;
  logic                  w_ld_push;
  logic                  w_pop;
  wb_entry_t [DEPTH-1:0] w_age_entry;
  logic [DEPTH-1:0]      w_age_valid;
  logic                  r_en;
  logic [ADDR_W-1:0]     r_rw;
  logic [DATA_W-1:0]     r_busw;

  // Youngest match wins: port word first, then queue entries oldest to newest.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0]     idx,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]      vld,
    input logic                  port_en,
    input logic [ADDR_W-1:0]     port_rd,
    input logic [DATA_W-1:0]     port_data
  );
    logic [DATA_W:0] res;
    res = {1'b0, {DATA_W{1'b0}}};
    if (port_en && (port_rd == idx)) begin
      res = {1'b1, port_data};
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ents[i].rd == idx)) begin
        res = {1'b1, ents[i].data};
      end
    end
    if (idx == {ADDR_W{1'b0}}) begin
      res = {1'b0, {DATA_W{1'b0}}};
    end
    return res;
  endfunction

  // Readiness looks only at current occupancy so it never depends on the pop.
  assign w_free     = CNT_W'(DEPTH) - w_count;
  assign alu_ready  = (w_free >= CNT_W'(1));
  assign ld_ready   = (w_free >= CNT_W'(2)) | ((w_free >= CNT_W'(1)) & ~alu_valid);
  assign w_alu_push = alu_valid & alu_ready & (alu_rd != {ADDR_W{1'b0}});
  assign w_ld_push  = ld_valid & ld_ready & (ld_rd != {ADDR_W{1'b0}});
  assign w_pop      = (w_count != {CNT_W{1'b0}});

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push0     (w_alu_push),
    .i_entry0    ({alu_rd, alu_data}),
    .i_push1     (w_ld_push),
    .i_entry1    ({ld_rd, ld_data}),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_age_entry (w_age_entry),
    .o_age_valid (w_age_valid)
  );

  // Write port register: one pulse per popped entry, address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_rw   <= {ADDR_W{1'b0}};
      r_busw <= {DATA_W{1'b0}};
    end else if (w_pop) begin
      r_en   <= 1'b1;
      r_rw   <= w_age_entry[0].rd;
      r_busw <= w_age_entry[0].data;
    end else begin
      r_en   <= 1'b0;
    end
  end

  assign enableWrite = r_en;
  assign RW          = r_rw;
  assign BusW        = r_busw;
  assign empty       = (w_count == {CNT_W{1'b0}}) & ~r_en;

  // Forwarding for both decode read ports.
  always_comb begin
    {fwd_a_hit, fwd_a_data} = fwd_lookup(fwd_ra, w_age_entry, w_age_valid, r_en, r_rw, r_busw);
    {fwd_b_hit, fwd_b_data} = fwd_lookup(fwd_rb, w_age_entry, w_age_valid, r_en, r_rw, r_busw);
  end

endmodule
